// File: rtl/stack_pkg.sv
// Shared constants for the stack command driver: defaults, opcodes, FSM encoding.
package stack_pkg;

    localparam int STACK_DATA_W = 4;
    localparam int STACK_DEPTH  = 8;

    // Command opcodes carried on cmd_op.
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    // Driver FSM encoding, also visible on the dbg_state port.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Read-latency countdown width; RD_LAT is at most 4.
    localparam int WAIT_W = 3;

endpackage

// File: rtl/stack_cmd_driver_if.sv
// Command/response stream bundle between the command source and the driver.
// Handshake rule for both streams: a transfer happens on the rising clk edge
// where valid and ready are both high; the producer holds valid and payload
// stable until that edge and never withdraws valid before it.
interface stack_cmd_if #(
    parameter int DATA_W = 4
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // Command source / response consumer side.
    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    // Driver side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_level_tracker.sv
// Shadow occupancy counter for the attached stack, with a bound guard and a
// sticky flag raised whenever the shadow view and the stack flags disagree.
module stack_level_tracker #(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             chk_en_i,
    input  logic             stk_full_i,
    input  logic             stk_empty_i,
    output logic [LVL_W-1:0] level_o,
    output logic             desync_o
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [LVL_W-1:0] level_q, level_d;
    logic             desync_q, desync_d;

    // Next level with saturation; an out-of-range step or a flag mismatch while idle latches desync.
    always_comb begin
        level_d  = level_q;
        desync_d = desync_q;
        if (inc_i) begin
            if (level_q == FULL_LVL) desync_d = 1'b1;
            else                     level_d  = level_q + LVL_W'(1);
        end else if (dec_i) begin
            if (level_q == '0) desync_d = 1'b1;
            else               level_d  = level_q - LVL_W'(1);
        end
        if (chk_en_i && ((stk_full_i != (level_q == FULL_LVL)) ||
                         (stk_empty_i != (level_q == '0)))) begin
            desync_d = 1'b1;
        end
    end

    // Level and sticky desync registers; only rst clears desync.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q  <= '0;
            desync_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            desync_q <= desync_d;
        end
    end

    assign level_o  = level_q;
    assign desync_o = desync_q;

endmodule

// File: rtl/stack_cmd_driver.sv
// Initiator side of the stack push/pop interface: accepts one command at a
// time, rejects illegal push/pop using the stack's own flags, issues a single
// cycle pulse otherwise, waits out the read latency on pops and returns one
// registered response per command.
module stack_cmd_driver
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int RD_LAT = 1,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    stack_cmd_if.slave        cmd,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_din,
    input  logic [DATA_W-1:0] stk_dout,
    input  logic              stk_full,
    input  logic              stk_empty,
    output logic [LVL_W-1:0]  level,
    output logic              desync,
    output logic [1:0]        dbg_state
);

    logic [1:0]        state_q, state_d;
    logic              op_q, op_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              stk_push_q, stk_push_d;
    logic              stk_pop_q, stk_pop_d;
    logic [DATA_W-1:0] stk_din_q, stk_din_d;

    // FSM next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_cnt_d  = wait_cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        stk_din_d   = stk_din_q;
        stk_push_d  = 1'b0;
        stk_pop_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d        = cmd.cmd_op;
                    cmd_ready_d = 1'b0;
                    if ((cmd.cmd_op == OP_PUSH && stk_full) ||
                        (cmd.cmd_op == OP_POP && stk_empty)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d    = ST_ISSUE;
                        stk_push_d = (cmd.cmd_op == OP_PUSH);
                        stk_pop_d  = (cmd.cmd_op == OP_POP);
                        stk_din_d  = cmd.cmd_data;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_q == OP_PUSH) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_W'(RD_LAT);
                end
            end
            ST_WAIT: begin
                // Count of 1 marks the cycle in which stk_dout carries the popped word.
                if (wait_cnt_q == WAIT_W'(1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = stk_dout;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            ST_RESP: begin
                if (cmd.rsp_ready) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any pulse, wait or response in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PUSH;
            wait_cnt_q  <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            stk_push_q  <= 1'b0;
            stk_pop_q   <= 1'b0;
            stk_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wait_cnt_q  <= wait_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            stk_push_q  <= stk_push_d;
            stk_pop_q   <= stk_pop_d;
            stk_din_q   <= stk_din_d;
        end
    end

    // Shadow level follows the issued pulses; flags are compared only while idle.
    stack_level_tracker #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_level (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (stk_push_q),
        .dec_i       (stk_pop_q),
        .chk_en_i    (state_q == ST_IDLE),
        .stk_full_i  (stk_full),
        .stk_empty_i (stk_empty),
        .level_o     (level),
        .desync_o    (desync)
    );

    assign cmd.cmd_ready = cmd_ready_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_err   = rsp_err_q;
    assign cmd.rsp_data  = rsp_data_q;
    assign stk_push      = stk_push_q;
    assign stk_pop       = stk_pop_q;
    assign stk_din       = stk_din_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_stack_cmd_driver.sv
// Bench for stack_cmd_driver against a behavioural 8-deep stack with a
// one-cycle read latency. Inputs change and outputs are sampled on the
// falling edge.
module tb_stack_cmd_driver;
    import stack_pkg::*;

    localparam int DW = 4;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          stk_push, stk_pop;
    logic [DW-1:0] stk_din;
    logic [DW-1:0] stk_dout;
    logic          stk_full, stk_empty;
    logic [3:0]    level;
    logic          desync;
    logic [1:0]    dbg_state;
    logic          force_ne;

    stack_cmd_if #(.DATA_W(DW)) cif ();

    stack_cmd_driver #(.DATA_W(DW), .DEPTH(DP), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cif),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_din   (stk_din),
        .stk_dout  (stk_dout),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .level     (level),
        .desync    (desync),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural stack, RD_LAT = 1 ----------------
    logic [DW-1:0] mem [DP];
    int            sp;

    always @(posedge clk) begin
        if (rst) begin
            sp       <= 0;
            stk_dout <= '0;
        end else if (stk_push && sp < DP) begin
            mem[sp] <= stk_din;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_dout <= mem[sp-1];
            sp       <= sp - 1;
        end
    end

    assign stk_full  = (sp == DP);
    assign stk_empty = (sp == 0) && !force_ne;

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    int            push_cnt = 0;
    int            pop_cnt = 0;
    logic          prev_push = 1'b0;
    logic          prev_pop = 1'b0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor: widths of one cycle and push data in issue order.
    always @(negedge clk) begin
        if (stk_push) begin
            push_cnt++;
            if (exp_q.size() == 0) chk("unexpected_push", 32'(stk_din), 32'hFFFF);
            else                   chk("stk_din", 32'(stk_din), 32'(exp_q.pop_front()));
        end
        if (stk_pop) pop_cnt++;
        if (stk_push && prev_push) chk("push_width", 32'd2, 32'd1);
        if (stk_pop && prev_pop)   chk("pop_width", 32'd2, 32'd1);
        prev_push = stk_push;
        prev_pop  = stk_pop;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          op;
        logic [DW-1:0] data;
        logic          exp_err;
        logic [DW-1:0] exp_data;
        int            exp_lat;
        logic [3:0]    exp_level;
        int            hold;
    } vec_t;

    vec_t vecs[17];

    // Drive one command, measure response latency, optionally stall the
    // response, then complete the handshake and check the aftermath.
    task automatic run_cmd(input vec_t v, input int idx);
        int cyc;
        int pc0, pp0;
        string tag;
        tag = $sformatf("v%0d", idx);
        pc0 = push_cnt;
        pp0 = pop_cnt;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = v.op;
        cif.cmd_data  = v.data;
        cyc = 0;
        while (!cif.cmd_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!cif.cmd_ready) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
            cif.cmd_valid = 1'b0;
            return;
        end
        if (v.op == OP_PUSH && !v.exp_err) exp_q.push_back(v.data);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) cif.cmd_valid = 1'b0;
        end while (!cif.rsp_valid && cyc < 20);
        chk({tag, "_rsp_latency"}, 32'(cyc), 32'(v.exp_lat));
        chk({tag, "_rsp_err"}, 32'(cif.rsp_err), 32'(v.exp_err));
        chk({tag, "_rsp_data"}, 32'(cif.rsp_data), 32'(v.exp_data));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(cif.rsp_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(cif.rsp_data), 32'(v.exp_data));
            chk({tag, "_hold_ready"}, 32'(cif.cmd_ready), 32'd0);
        end
        cif.rsp_ready = 1'b1;
        @(negedge clk);
        cif.rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, 32'(cif.rsp_valid), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cif.cmd_ready), 32'd1);
        chk({tag, "_level"}, 32'(level), 32'(v.exp_level));
        chk({tag, "_desync"}, 32'(desync), 32'd0);
        chk({tag, "_push_pulses"}, 32'(push_cnt - pc0),
            (v.op == OP_PUSH && !v.exp_err) ? 32'd1 : 32'd0);
        chk({tag, "_pop_pulses"}, 32'(pop_cnt - pp0),
            (v.op == OP_POP && !v.exp_err) ? 32'd1 : 32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        chk({tag, "_cmd_ready"}, 32'(cif.cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(cif.rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(cif.rsp_err), 32'd0);
        chk({tag, "_rsp_data"}, 32'(cif.rsp_data), 32'd0);
        chk({tag, "_stk_push"}, 32'(stk_push), 32'd0);
        chk({tag, "_stk_pop"}, 32'(stk_pop), 32'd0);
        chk({tag, "_stk_din"}, 32'(stk_din), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_desync"}, 32'(desync), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //          op       data   err   rdata  lat lvl hold
        vecs[0]  = '{OP_POP,  4'h0, 1'b1, 4'h0, 1, 4'd0, 0};
        vecs[1]  = '{OP_PUSH, 4'h1, 1'b0, 4'h0, 2, 4'd1, 0};
        vecs[2]  = '{OP_PUSH, 4'h2, 1'b0, 4'h0, 2, 4'd2, 0};
        vecs[3]  = '{OP_PUSH, 4'h3, 1'b0, 4'h0, 2, 4'd3, 0};
        vecs[4]  = '{OP_PUSH, 4'h4, 1'b0, 4'h0, 2, 4'd4, 0};
        vecs[5]  = '{OP_POP,  4'h0, 1'b0, 4'h4, 3, 4'd3, 0};
        vecs[6]  = '{OP_POP,  4'h0, 1'b0, 4'h3, 3, 4'd2, 0};
        vecs[7]  = '{OP_PUSH, 4'h5, 1'b0, 4'h0, 2, 4'd3, 0};
        vecs[8]  = '{OP_PUSH, 4'h6, 1'b0, 4'h0, 2, 4'd4, 0};
        vecs[9]  = '{OP_PUSH, 4'h7, 1'b0, 4'h0, 2, 4'd5, 0};
        vecs[10] = '{OP_PUSH, 4'h8, 1'b0, 4'h0, 2, 4'd6, 0};
        vecs[11] = '{OP_PUSH, 4'h9, 1'b0, 4'h0, 2, 4'd7, 0};
        vecs[12] = '{OP_PUSH, 4'hC, 1'b0, 4'h0, 2, 4'd8, 0};
        vecs[13] = '{OP_PUSH, 4'hA, 1'b1, 4'h0, 1, 4'd8, 0};
        vecs[14] = '{OP_POP,  4'h0, 1'b0, 4'hC, 3, 4'd7, 0};
        vecs[15] = '{OP_PUSH, 4'hB, 1'b0, 4'h0, 2, 4'd8, 0};
        vecs[16] = '{OP_POP,  4'h0, 1'b0, 4'hB, 3, 4'd7, 5};

        rst           = 1'b1;
        force_ne      = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = OP_PUSH;
        cif.cmd_data  = '0;
        cif.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) run_cmd(vecs[i], i);
        chk("push_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a pop's read-latency wait.
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = OP_POP;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("mid_pop_pulse", 32'(stk_pop), 32'd1);
        @(negedge clk);
        chk("mid_wait_state", 32'(dbg_state), 32'(ST_WAIT));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_values("mid_reset");

        // Stack claims non-empty while the shadow level is 0.
        force_ne = 1'b1;
        @(negedge clk);
        chk("desync_set", 32'(desync), 32'd1);
        force_ne = 1'b0;
        repeat (3) @(negedge clk);
        chk("desync_sticky", 32'(desync), 32'd1);
        chk("desync_level", 32'(level), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("desync_cleared", 32'(desync), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
